reg_xchg_scheduler: RTL and testbench

- Round-robin scheduler that shares a small register bank among NUM_REQ requesters.
- Serialises write, swap, copy and read commands, one granted command at a time.
- Every command commits atomically at a single clock edge, with nonblocking semantics: all reads see pre-edge values, so a swap needs no temporaries.
- Sits between behavioural requester models and the shared register datapath.

---
 rtl/reg_xchg_scheduler.sv | 158 +++++++++++++++
 tb/tb_reg_xchg_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_xchg_scheduler.sv
// Round-robin scheduler that serialises WRITE/SWAP/COPY/READ commands onto a shared register bank.
// Optional `XCHG_OP_COUNT_EN` adds a saturating 16-bit count of committed commands.
module reg_xchg_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      op,
  input  logic [ADDR_W*NUM_REQ-1:0] addr_a,
  input  logic [ADDR_W*NUM_REQ-1:0] addr_b,
  input  logic [WIDTH*NUM_REQ-1:0]  wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          rd_a,
  output logic [WIDTH-1:0]          rd_b
`ifdef XCHG_OP_COUNT_EN
  ,
  output logic [15:0]               op_count
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [WIDTH-1:0]   bank_q [DEPTH];
  logic [WIDTH-1:0]   bank_d [DEPTH];
  logic [1:0]         op_q, op_d;
  logic [ADDR_W-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               found;
  logic [IDX_W-1:0]   arb_idx;

  // Search starts one past the last winner and wraps, giving strict rotation.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[IDX_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
        found   = 1'b1;
        arb_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    bank_d  = bank_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_EXEC;
          win_d   = arb_idx;
          gnt_d   = NUM_REQ'(1) << arb_idx;
          busy_d  = 1'b1;
          op_d    = op[2*arb_idx +: 2];
          a_d     = addr_a[ADDR_W*arb_idx +: ADDR_W];
          b_d     = addr_b[ADDR_W*arb_idx +: ADDR_W];
          wdata_d = wdata[WIDTH*arb_idx +: WIDTH];
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ptr_d   = win_q;
        rd_a_d  = bank_q[a_q];
        rd_b_d  = bank_q[b_q];
        // All right-hand sides read bank_q, so SWAP with a==b is naturally a no-op.
        case (op_q)
          OP_WRITE: bank_d[a_q] = wdata_q;
          OP_SWAP: begin
            bank_d[a_q] = bank_q[b_q];
            bank_d[b_q] = bank_q[a_q];
          end
          OP_COPY:  bank_d[b_q] = bank_q[a_q];
          default:  ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      bank_q  <= bank_d;
    end
  end

  // Latched command fields are only consumed in EXEC, so they carry no reset.
  always_ff @(posedge clock) begin
    win_q   <= win_d;
    op_q    <= op_d;
    a_q     <= a_d;
    b_q     <= b_d;
    wdata_q <= wdata_d;
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;

`ifdef XCHG_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == S_EXEC && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) op_count_q <= '0;
    else          op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_reg_xchg_scheduler.sv
// Directed bench for reg_xchg_scheduler: command vector table plus reset and round-robin sequences.
module tb_reg_xchg_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int AW   = 2;

  logic              clock;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [AW*NREQ-1:0] addr_a, addr_b;
  logic [W*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic              busy, done;
  logic [W-1:0]      rd_a, rd_b;
`ifdef XCHG_OP_COUNT_EN
  logic [15:0]       op_count;
`endif

  reg_xchg_scheduler #(.NUM_REQ(NREQ), .WIDTH(W), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .wdata(wdata),
    .gnt(gnt), .busy(busy), .done(done), .rd_a(rd_a), .rd_b(rd_b)
`ifdef XCHG_OP_COUNT_EN
    , .op_count(op_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         r;
    logic [1:0] opc;
    logic [1:0] a;
    logic [1:0] b;
    logic [15:0] wd;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [12];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input int r, input logic [1:0] opc, input logic [1:0] a,
                         input logic [1:0] b, input logic [15:0] wd);
    req[r]          = 1'b1;
    op[2*r +: 2]    = opc;
    addr_a[AW*r +: AW] = a;
    addr_b[AW*r +: AW] = b;
    wdata[W*r +: W] = wd;
  endtask

  initial begin
    // r, op, a, b, wdata, expected rd_a, expected rd_b
    vecs[0]  = '{0, 2'b11, 2'd0, 2'd3, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 2'b00, 2'd1, 2'd0, 16'hA5A5, 16'h0000, 16'h0000};
    vecs[2]  = '{1, 2'b11, 2'd1, 2'd0, 16'h0000, 16'hA5A5, 16'h0000};
    vecs[3]  = '{3, 2'b00, 2'd2, 2'd1, 16'h1234, 16'h0000, 16'hA5A5};
    vecs[4]  = '{2, 2'b01, 2'd1, 2'd2, 16'h0000, 16'hA5A5, 16'h1234};
    vecs[5]  = '{0, 2'b11, 2'd1, 2'd2, 16'h0000, 16'h1234, 16'hA5A5};
    vecs[6]  = '{1, 2'b00, 2'd3, 2'd0, 16'h00FF, 16'h0000, 16'h0000};
    vecs[7]  = '{2, 2'b01, 2'd3, 2'd3, 16'h0000, 16'h00FF, 16'h00FF};
    vecs[8]  = '{3, 2'b10, 2'd3, 2'd3, 16'h0000, 16'h00FF, 16'h00FF};
    vecs[9]  = '{0, 2'b11, 2'd3, 2'd3, 16'h0000, 16'h00FF, 16'h00FF};
    vecs[10] = '{1, 2'b10, 2'd1, 2'd0, 16'h0000, 16'h1234, 16'h0000};
    vecs[11] = '{2, 2'b11, 2'd0, 2'd1, 16'h0000, 16'h1234, 16'h1234};

    reset_n = 1'b0;
    req = '0; op = '0; addr_a = '0; addr_b = '0; wdata = '0;
    #12;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_rd_a", 32'(rd_a), 32'h0);
    chk("reset_rd_b", 32'(rd_b), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      present(vecs[i].r, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].wd);
      step();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(1) << vecs[i].r);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      chk($sformatf("v%0d_done_early", i), 32'(done), 32'h0);
      req = '0;
      step();
      chk($sformatf("v%0d_gnt_off", i), 32'(gnt), 32'h0);
      chk($sformatf("v%0d_done", i), 32'(done), 32'h1);
      chk($sformatf("v%0d_rd_a", i), 32'(rd_a), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d_rd_b", i), 32'(rd_b), 32'(vecs[i].exp_b));
    end
`ifdef XCHG_OP_COUNT_EN
    chk("op_count_table", 32'(op_count), 32'd12);
`endif

    // Asynchronous reset while a WRITE from requester 1 is in EXEC.
    present(1, 2'b00, 2'd0, 2'd0, 16'hBEEF);
    step();
    chk("rst_exec_gnt", 32'(gnt), 32'h2);
    req = '0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_done", 32'(done), 32'h0);
    chk("rst_async_rd_a", 32'(rd_a), 32'h0);
    chk("rst_async_rd_b", 32'(rd_b), 32'h0);
    step();
    step();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("rst_no_done", 32'(done), 32'h0);
    present(0, 2'b11, 2'd0, 2'd1, 16'h0000);
    present(1, 2'b11, 2'd0, 2'd1, 16'h0000);
    step();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    chk("rst_reg0_done", 32'(done), 32'h1);
    chk("rst_reg0", 32'(rd_a), 32'h0);
    chk("rst_reg1", 32'(rd_b), 32'h0);

    // Fresh reset, then all four requesters held high.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    op = '1;
    req = '1;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(1) << (g % 4));
      chk($sformatf("rr%0d_busy", g), 32'(busy), 32'h1);
      if (g == 4) req = '0;
      step();
      chk($sformatf("rr%0d_gap", g), 32'(gnt), 32'h0);
      chk($sformatf("rr%0d_done", g), 32'(done), 32'h1);
    end
`ifdef XCHG_OP_COUNT_EN
    chk("op_count_rr", 32'(op_count), 32'd5);
`endif
    step();
    chk("rr_idle_gnt", 32'(gnt), 32'h0);
    chk("rr_idle_done", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
